kpscan: RTL and testbench

KPSCAN -- requirements
Module: kpscan

---
 rtl/kpscan_pkg.sv | 21 ++
 rtl/kpscan_sync.sv | 28 ++
 rtl/kpscan.sv | 183 ++++++++++++++++++
 tb/tb_kpscan.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kpscan_pkg.sv
// kpscan shared types: scanner state encoding and key code helper.
// Imported by the scanner top and reused wherever a key code is formed.
package kpscan_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    // Linear key number in row-major order.
    function automatic int unsigned kp_code(
        input int unsigned row,
        input int unsigned col,
        input int unsigned ncols
    );
        return row * ncols + col;
    endfunction

endpackage

// File: rtl/kpscan_sync.sv
// kpscan_sync: W-bit two-flop synchronizer for asynchronous inputs.
// Resets to all ones, the idle (no key) level of the keypad rows.
module kpscan_sync #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two-stage capture; only sync_q is used by downstream logic.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/kpscan.sv
// kpscan: matrix keypad scanner with press/release debounce.
// Drives one active-low column at a time and reports one debounced key.
module kpscan #(
    parameter int NROWS        = 4,
    parameter int NCOLS        = 4,
    parameter int SCAN_CYC     = 1000,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int CW           = $clog2(NROWS * NCOLS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NROWS-1:0] kpr,
    output logic [NCOLS-1:0] kpc,
    output logic [CW-1:0]    key_code,
    output logic             key_valid,
    output logic             kphit,
    output logic             multi_err
);

    import kpscan_pkg::*;

    localparam int MAXC = (SCAN_CYC > DEBOUNCE_CYC) ? SCAN_CYC : DEBOUNCE_CYC;
    localparam int CNTW = $clog2(MAXC);
    localparam int RW   = $clog2(NROWS);
    localparam int CLW  = $clog2(NCOLS);

    // Scan sample point, and last count of a debounce window. The
    // window's first matching cycle is the one that triggered it
    // (scan sample or first released cycle), so the counter stops
    // one short of DEBOUNCE_CYC-1.
    localparam logic [CNTW-1:0] SCAN_LAST = CNTW'(SCAN_CYC - 1);
    localparam logic [CNTW-1:0] DEB_LAST  = CNTW'(DEBOUNCE_CYC - 2);
    localparam logic [CLW-1:0]  COL_LAST  = CLW'(NCOLS - 1);

    logic [NROWS-1:0] rs;

    kp_state_e        state_q, state_d;
    logic [CNTW-1:0]  cnt_q,   cnt_d;
    logic [CLW-1:0]   col_q,   col_d;
    logic [RW-1:0]    row_q,   row_d;
    logic [CW-1:0]    code_q,  code_d;
    logic             valid_q, valid_d;
    logic             hit_q,   hit_d;
    logic             merr_q,  merr_d;

    logic [3:0]       nlow;
    logic [RW-1:0]    low_idx;
    logic [NROWS-1:0] row_pat;
    logic [CLW-1:0]   col_nxt;

    kpscan_sync #(
        .W(NROWS)
    ) u_sync (
        .clk_i   (clk),
        .rst_n_i (reset_n),
        .d_i     (kpr),
        .q_o     (rs)
    );

    // Count low rows and remember which one is low.
    always_comb begin
        nlow    = '0;
        low_idx = '0;
        for (int i = 0; i < NROWS; i++) begin
            if (!rs[i]) begin
                nlow    = nlow + 4'd1;
                low_idx = RW'(i);
            end
        end
    end

    // Expected row pattern for the latched key and the wrapped next column.
    always_comb begin
        row_pat = ~(NROWS'(1) << row_q);
        col_nxt = (col_q == COL_LAST) ? '0 : col_q + CLW'(1);
    end

    // Next-state logic for the scan / debounce / hold / release walk.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        code_d  = code_q;
        valid_d = 1'b0;
        hit_d   = hit_q;
        merr_d  = 1'b0;

        unique case (state_q)
            ST_SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (nlow == 4'd0) begin
                        col_d = col_nxt;
                    end else if (nlow == 4'd1) begin
                        row_d   = low_idx;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        merr_d = 1'b1;
                        col_d  = col_nxt;
                    end
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end

            ST_DEBOUNCE: begin
                if (rs != row_pat) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    code_d  = CW'(kp_code(32'(row_q), 32'(col_q), NCOLS));
                    valid_d = 1'b1;
                    hit_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end

            ST_HELD: begin
                if (rs[row_q]) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end
            end

            ST_RELEASE: begin
                if (!rs[row_q]) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                    hit_d   = 1'b0;
                    col_d   = col_nxt;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end

            default: begin
                state_d = ST_SCAN;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_SCAN;
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            hit_q   <= 1'b0;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            hit_q   <= hit_d;
            merr_q  <= merr_d;
        end
    end

    // One-hot active-low column drive decoded from the column register.
    always_comb begin
        kpc = ~(NCOLS'(1) << col_q);
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign kphit     = hit_q;
    assign multi_err = merr_q;

endmodule

// File: tb/tb_kpscan.sv
// tb_kpscan: randomized and directed checks of kpscan against a
// run-length keypad model, with a few hand-computed pins.
module tb_kpscan;

    localparam int NR = 4;
    localparam int NC = 4;
    localparam int SC = 4;
    localparam int DB = 8;

    localparam int M_SCAN = 0;
    localparam int M_CONF = 1;
    localparam int M_DOWN = 2;
    localparam int M_LIFT = 3;

    typedef struct {
        int         mode;
        int         col;
        int         row;
        int         dwell;
        int         run;
        logic [3:0] s1;
        logic [3:0] rs;
        logic [3:0] code;
        logic       valid;
        logic       hit;
        logic       merr;
    } mdl_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] kpr = 4'hF;
    logic [3:0] kpc;
    logic [3:0] key_code;
    logic       key_valid;
    logic       kphit;
    logic       multi_err;

    logic [15:0] pk = '0;
    logic [3:0]  one4 = 4'b0001;
    logic [3:0]  tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic        chk_en = 1'b0;

    int tests = 0;
    int fails = 0;
    int nvalid = 0;
    int nmerr = 0;

    mdl_t m;

    kpscan #(
        .NROWS(NR),
        .NCOLS(NC),
        .SCAN_CYC(SC),
        .DEBOUNCE_CYC(DB)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .kpr(kpr),
        .kpc(kpc),
        .key_code(key_code),
        .key_valid(key_valid),
        .kphit(kphit),
        .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] row_mask(input int r);
        logic [3:0] b;
        b = 4'b0001;
        return ~(b << r);
    endfunction

    // Rows seen by the physical keypad for the given column drive.
    function automatic logic [3:0] keypad(input logic [3:0] cols,
                                          input logic [15:0] keys);
        logic [3:0] rows;
        rows = 4'hF;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (keys[r*NC+c] && !cols[c]) rows[r] = 1'b0;
        return rows;
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t n;
        n.mode = M_SCAN;
        n.col = 0;
        n.row = 0;
        n.dwell = 0;
        n.run = 0;
        n.s1 = 4'hF;
        n.rs = 4'hF;
        n.code = 4'h0;
        n.valid = 1'b0;
        n.hit = 1'b0;
        n.merr = 1'b0;
        return n;
    endfunction

    // One clock of the keypad rules, phrased as dwell time and run lengths
    // of matching rows; c.rs is the row value visible during the cycle.
    function automatic mdl_t model_next(input mdl_t c, input logic [3:0] raw);
        mdl_t n;
        int lows;
        int idx;
        n = c;
        n.valid = 1'b0;
        n.merr = 1'b0;
        lows = 0;
        idx = 0;
        for (int i = 0; i < NR; i++)
            if (!c.rs[i]) begin
                lows++;
                idx = i;
            end
        case (c.mode)
            M_SCAN: begin
                n.dwell = c.dwell + 1;
                if (n.dwell == SC) begin
                    n.dwell = 0;
                    if (lows == 1) begin
                        n.mode = M_CONF;
                        n.run = 1;
                        n.row = idx;
                    end else begin
                        if (lows > 1) n.merr = 1'b1;
                        n.col = (c.col + 1) % NC;
                    end
                end
            end
            M_CONF: begin
                if (c.rs != row_mask(c.row)) begin
                    n.mode = M_SCAN;
                    n.dwell = 0;
                end else begin
                    n.run = c.run + 1;
                    if (n.run == DB) begin
                        n.mode = M_DOWN;
                        n.valid = 1'b1;
                        n.hit = 1'b1;
                        n.code = 4'(c.row * NC + c.col);
                    end
                end
            end
            M_DOWN: begin
                if (c.rs[c.row]) begin
                    n.mode = M_LIFT;
                    n.run = 1;
                end
            end
            M_LIFT: begin
                if (!c.rs[c.row]) begin
                    n.mode = M_DOWN;
                end else begin
                    n.run = c.run + 1;
                    if (n.run == DB) begin
                        n.mode = M_SCAN;
                        n.dwell = 0;
                        n.hit = 1'b0;
                        n.col = (c.col + 1) % NC;
                    end
                end
            end
            default: n.mode = M_SCAN;
        endcase
        n.rs = c.s1;
        n.s1 = raw;
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= mdl_reset();
        else m <= model_next(m, kpr);
    end

    // Compare process: every cycle against the model.
    initial begin
        logic [3:0] ek;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                ek = ~(one4 << m.col);
                check("kpc", kpc, ek);
                check("key_code", key_code, m.code);
                check("key_valid", key_valid, m.valid);
                check("kphit", kphit, m.hit);
                check("multi_err", multi_err, m.merr);
                if (key_valid) nvalid++;
                if (multi_err) nmerr++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            kpr = keypad(kpc, pk);
        end
    endtask

    task automatic wait_hit(input logic lvl, input int lim);
        int n;
        n = 0;
        while (kphit !== lvl && n < lim) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        int v0;
        int m0;
        int n;
        int left;
        int sel;
        int hold;
        int bk;
        logic early;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("rst_kpc", kpc, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_hit", kphit, 1'b0);
        check("rst_merr", multi_err, 1'b0);
        chk_en = 1'b1;

        // Idle walk: each column for four cycles, wrapping.
        for (int i = 0; i < 64; i++) begin
            step(1);
            check("idle_walk", kpc, tbl[((i + 1) / 4) % 4]);
        end
        check("idle_valid", nvalid, 0);
        check("idle_merr", nmerr, 0);

        // Key row 2 / col 1.
        v0 = nvalid;
        pk[2*NC+1] = 1'b1;
        wait_hit(1'b1, 200);
        step(20);
        check("k9_valid_cnt", nvalid - v0, 1);
        check("k9_code", key_code, 4'd9);
        check("k9_hit", kphit, 1'b1);
        pk = '0;
        step(1);
        n = 0;
        while (kphit && n < 40) begin
            step(1);
            n++;
        end
        // 2 synchronizer cycles plus 8 debounce cycles.
        check("k9_release_lat", n, 10);

        // Bounce: three low, one high, never stable long enough.
        v0 = nvalid;
        for (int k = 0; k < 96; k++) begin
            pk[2*NC+1] = ((k % 4) != 3);
            step(1);
        end
        check("bounce_valid", nvalid - v0, 0);
        pk[2*NC+1] = 1'b1;
        wait_hit(1'b1, 200);
        step(10);
        check("bounce_stable_valid", nvalid - v0, 1);
        pk = '0;
        wait_hit(1'b0, 60);
        check("bounce_release", kphit, 1'b0);

        // Two rows low under column 2.
        v0 = nvalid;
        m0 = nmerr;
        pk[0*NC+2] = 1'b1;
        pk[3*NC+2] = 1'b1;
        n = 0;
        while (!multi_err && n < 40) begin
            step(1);
            n++;
        end
        check("multi_pulse", multi_err, 1'b1);
        check("multi_next_col", kpc, 4'b0111);
        step(10);
        check("multi_valid", nvalid - v0, 0);
        check("multi_seen", (nmerr - m0) > 0, 1'b1);
        pk = '0;
        step(4);

        // Release glitch on key row 1 / col 3.
        v0 = nvalid;
        pk[1*NC+3] = 1'b1;
        wait_hit(1'b1, 200);
        step(5);
        early = 1'b0;
        pk = '0;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) pk[1*NC+3] = 1'b1;
            step(1);
            if (!kphit) early = 1'b1;
        end
        pk = '0;
        step(4);
        if (!kphit) early = 1'b1;
        check("glitch_hit_held", early, 1'b0);
        wait_hit(1'b0, 60);
        check("glitch_valid_cnt", nvalid - v0, 1);
        check("glitch_code_kept", key_code, 4'd7);

        // Reset during debounce of key row 3 / col 0.
        v0 = nvalid;
        pk[3*NC+0] = 1'b1;
        n = 0;
        while (m.mode != M_CONF && n < 100) begin
            step(1);
            n++;
        end
        check("deb_reached", m.mode, M_CONF);
        step(3);
        #2 reset_n = 1'b0;
        #1;
        check("arst_kpc", kpc, 4'b1110);
        check("arst_code", key_code, 4'h0);
        check("arst_valid", key_valid, 1'b0);
        check("arst_hit", kphit, 1'b0);
        check("arst_merr", multi_err, 1'b0);
        pk = '0;
        step(2);
        reset_n = 1'b1;
        check("arst_col0", kpc, 4'b1110);
        step(4);
        check("arst_col1", kpc, 4'b1101);
        step(12);
        check("arst_no_valid", nvalid - v0, 0);

        // Random keypad activity.
        left = 3000;
        while (left > 0) begin
            sel = $urandom_range(0, 9);
            hold = $urandom_range(1, 80);
            bk = $urandom_range(0, 15);
            pk = '0;
            if (sel >= 4) pk[bk] = 1'b1;
            if (sel == 8) pk[$urandom_range(0, 15)] = 1'b1;
            for (int k = 0; k < hold; k++) begin
                if (sel == 9) pk[bk] = ($urandom_range(0, 3) != 0);
                step(1);
            end
            left -= hold;
        end
        pk = '0;
        step(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
